// File: rtl/comm_master_nb.sv
// rtl/comm_master_nb.sv - N-byte command transmitter over an 8N1 UART, MSB byte first
// Optional even-parity bit per byte when COMM_MASTER_PARITY_EN is defined (8E1 frame).
module comm_master_nb #(
    parameter int NUM_BYTES = 2,
    parameter int BAUD_DIV  = 2604
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             snd_cmd,
    input  logic [8*NUM_BYTES-1:0]           cmd,
    output logic                             TX,
    output logic                             busy,
    output logic                             cmd_cmplt,
    output logic [$clog2(NUM_BYTES+1)-1:0]   byte_idx
);

    localparam int DW = 8 * NUM_BYTES;
    localparam int CW = $clog2(BAUD_DIV);
    localparam int BW = $clog2(NUM_BYTES + 1);

    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef COMM_MASTER_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [BW-1:0]   byte_q, byte_d;
    logic [DW-1:0]   shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            cmplt_q, cmplt_d;

    logic [7:0]      cur_byte;
    logic            baud_wrap;

    // The byte on the wire is always the top byte of the shift buffer;
    // the buffer moves up one byte only when a stop bit ends.
    assign cur_byte  = shift_q[DW-1 -: 8];
    assign baud_wrap = (baud_q == BAUD_LAST);

    // Next-state logic: TX is decided one cycle ahead so the line is a clean flop output.
    always_comb begin
        state_d = state_q;
        baud_d  = (state_q == S_IDLE || baud_wrap) ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        cmplt_d = cmplt_q;

        case (state_q)
            S_IDLE: begin
                if (snd_cmd && !busy_q) begin
                    shift_d = cmd;
                    state_d = S_START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    cmplt_d = 1'b0;
                    byte_d  = '0;
                    bit_d   = '0;
                    baud_d  = '0;
                end
            end
            S_START: begin
                if (baud_wrap) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    tx_d    = cur_byte[0];
                end
            end
            S_DATA: begin
                if (baud_wrap) begin
                    if (bit_q == 3'd7) begin
`ifdef COMM_MASTER_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = ^cur_byte;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = cur_byte[bit_q + 3'd1];
                    end
                end
            end
`ifdef COMM_MASTER_PARITY_EN
            S_PARITY: begin
                if (baud_wrap) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (baud_wrap) begin
                    byte_d = byte_q + 1'b1;
                    if (byte_q == BYTE_LAST) begin
                        // Last byte done: back to the waiting state with the sticky flag set.
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        cmplt_d = 1'b1;
                    end else begin
                        // Next byte starts immediately, no idle gap on the line.
                        state_d = S_START;
                        tx_d    = 1'b0;
                        shift_d = shift_q << 8;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset takes TX high immediately and drops the command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            cmplt_q <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            cmplt_q <= cmplt_d;
        end
    end

    assign TX        = tx_q;
    assign busy      = busy_q;
    assign cmd_cmplt = cmplt_q;
    assign byte_idx  = byte_q;

endmodule

// File: tb/tb_comm_master_nb.sv
// tb/tb_comm_master_nb.sv - self-checking bench for comm_master_nb (2-byte and 4-byte instances)
module tb_comm_master_nb;

`ifdef COMM_MASTER_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic        clk;
    logic        rst_n;
    logic        snd;
    logic        sel;
    logic [31:0] cmd_in;

    logic        snd2, snd4;
    logic        tx2, busy2, cmplt2;
    logic        tx4, busy4, cmplt4;
    logic [1:0]  bidx2;
    logic [2:0]  bidx4;

    logic        obs_tx, obs_busy, obs_cmplt;
    logic [2:0]  obs_bidx;

    int n_pass;
    int n_total;

    bit exp_bits[$];

    typedef struct {
        logic [31:0] cmd;
        bit          sel;
        int          pulse_at;
        logic [31:0] exp_rx;
    } vec_t;

    vec_t vecs[4];

    assign snd2 = snd & ~sel;
    assign snd4 = snd & sel;

    assign obs_tx    = sel ? tx4    : tx2;
    assign obs_busy  = sel ? busy4  : busy2;
    assign obs_cmplt = sel ? cmplt4 : cmplt2;
    assign obs_bidx  = sel ? bidx4  : {1'b0, bidx2};

    comm_master_nb #(.NUM_BYTES(2), .BAUD_DIV(16)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .snd_cmd   (snd2),
        .cmd       (cmd_in[15:0]),
        .TX        (tx2),
        .busy      (busy2),
        .cmd_cmplt (cmplt2),
        .byte_idx  (bidx2)
    );

    comm_master_nb #(.NUM_BYTES(4), .BAUD_DIV(8)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .snd_cmd   (snd4),
        .cmd       (cmd_in),
        .TX        (tx4),
        .busy      (busy4),
        .cmd_cmplt (cmplt4),
        .byte_idx  (bidx4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Reference line image: start, 8 data bits LSB first, optional even parity, stop; bytes MSB first.
    task automatic build_bits(input logic [31:0] c, input int n);
        logic [7:0] bv;
        exp_bits.delete();
        for (int j = n - 1; j >= 0; j--) begin
            bv = c[8*j +: 8];
            exp_bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) exp_bits.push_back(bv[i]);
            if (FB == 11) exp_bits.push_back(^bv);
            exp_bits.push_back(1'b1);
        end
    endtask

    // Send one command, check every cycle against the model, and decode the line mid-bit.
    task automatic run_frame(input logic [31:0] c, input bit s, input int pulse_at,
                             output logic [31:0] rx_seq);
        int n, b, len;
        bit rxq[$];
        logic [7:0] rxb;
        n   = s ? 4 : 2;
        b   = s ? 8 : 16;
        len = n * FB * b;
        build_bits(c, n);
        sel    = s;
        cmd_in = c;
        snd    = 1'b1;
        @(negedge clk);
        snd    = 1'b0;
        cmd_in = $urandom;
        for (int k = 1; k <= len; k++) begin
            chk("tx", obs_tx, exp_bits[(k-1)/b]);
            chk("busy", obs_busy, 1);
            chk("cmd_cmplt_low", obs_cmplt, 0);
            chk("byte_idx", obs_bidx, (k-1)/(FB*b));
            if ((k-1) % b == b/2) rxq.push_back(obs_tx);
            if (k == pulse_at) begin
                cmd_in = 32'hFFFF_FFFF;
                snd    = 1'b1;
            end else begin
                snd = 1'b0;
            end
            @(negedge clk);
        end
        snd = 1'b0;
        chk("cmd_cmplt_rise", obs_cmplt, 1);
        chk("busy_fall", obs_busy, 0);
        chk("tx_idle", obs_tx, 1);
        chk("byte_idx_final", obs_bidx, n);
        rx_seq = '0;
        for (int j = 0; j < n; j++) begin
            chk("rx_start", rxq[j*FB], 0);
            for (int i = 0; i < 8; i++) rxb[i] = rxq[j*FB + 1 + i];
            if (FB == 11) chk("rx_parity", rxq[j*FB + 9], ^rxb);
            chk("rx_stop", rxq[j*FB + FB - 1], 1);
            rx_seq = {rx_seq[23:0], rxb};
        end
    endtask

    initial begin
        logic [31:0] rx;
        logic [31:0] rc;
        bit          rs;
        int          rp;

        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        snd     = 1'b0;
        sel     = 1'b0;
        cmd_in  = '0;

        vecs[0] = '{cmd: 32'h0000_A55A, sel: 1'b0, pulse_at: -1,        exp_rx: 32'h0000_A55A};
        vecs[1] = '{cmd: 32'h0102_0304, sel: 1'b1, pulse_at: -1,        exp_rx: 32'h0102_0304};
        vecs[2] = '{cmd: 32'h0000_A55A, sel: 1'b0, pulse_at: 3*16 + 5,  exp_rx: 32'h0000_A55A};
        vecs[3] = '{cmd: 32'h0000_0701, sel: 1'b0, pulse_at: -1,        exp_rx: 32'h0000_0701};

        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_tx", obs_tx, 1);
            chk("rst_busy", obs_busy, 0);
            chk("rst_cmplt", obs_cmplt, 0);
            chk("rst_byte_idx", obs_bidx, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        sel = 1'b0;
        #1;
        chk("idle_tx", obs_tx, 1);
        chk("idle_busy", obs_busy, 0);
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            run_frame(vecs[v].cmd, vecs[v].sel, vecs[v].pulse_at, rx);
            chk("rx_bytes", rx, vecs[v].exp_rx);
        end

        // Flag stays high while idle, then a retrigger clears it the next cycle.
        for (int k = 0; k < 50; k++) begin
            chk("hold_cmplt", obs_cmplt, 1);
            chk("hold_busy", obs_busy, 0);
            chk("hold_tx", obs_tx, 1);
            @(negedge clk);
        end
        run_frame(32'h0000_00FF, 1'b0, -1, rx);
        chk("rx_bytes_00ff", rx, 32'h0000_00FF);

        // Reset during the 5th data bit of the first byte (0xA5 bit4 = 0).
        sel    = 1'b0;
        cmd_in = 32'h0000_A50F;
        snd    = 1'b1;
        @(negedge clk);
        snd = 1'b0;
        repeat (5*16 + 2) @(negedge clk);
        chk("pre_rst_tx", obs_tx, 0);
        chk("pre_rst_busy", obs_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", obs_tx, 1);
        chk("midrst_busy", obs_busy, 0);
        chk("midrst_cmplt", obs_cmplt, 0);
        chk("midrst_byte_idx", obs_bidx, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_tx", obs_tx, 1);
        chk("post_rst_busy", obs_busy, 0);
        run_frame(32'h0000_1234, 1'b0, -1, rx);
        chk("rx_bytes_1234", rx, 32'h0000_1234);

        // Randomized commands, instance choice and ignored retrigger pulses.
        for (int r = 0; r < 8; r++) begin
            rs = $urandom_range(0, 1);
            rc = $urandom;
            if (!rs) rc[31:16] = '0;
            rp = ($urandom_range(0, 1) == 1) ? $urandom_range(1, (rs ? 4*8 : 2*16) * FB - 1) : -1;
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_frame(rc, rs, rp, rx);
            chk("rx_bytes_rand", rx, rc);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
